// File: rtl/ccu_cfg_ctrl.sv
// Runtime configuration controller for the CCU.
// Software programs shadow registers, then requests a commit. The controller
// quiesces all slave ports, waits for the per-port outstanding counters to
// drain, and applies the shadow set to the active outputs in one cycle.
module ccu_cfg_ctrl #(
   parameter int unsigned            NoSlvPorts    = 4,
   parameter int unsigned            RegAddrWidth  = 8,
   parameter int unsigned            OutstWidth    = 8,
   parameter int unsigned            CmAddrWidth   = 32,
   parameter int unsigned            TimeoutCycles = 1024,
   parameter logic [NoSlvPorts-1:0]  PortEnRst     = '1,
   parameter logic [CmAddrWidth-1:0] CmAddrBaseRst = '0
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    reg_req_i,
   input  logic                    reg_we_i,
   input  logic [RegAddrWidth-1:0] reg_addr_i,
   input  logic [31:0]             reg_wdata_i,
   output logic                    reg_ready_o,
   output logic                    reg_rvalid_o,
   output logic [31:0]             reg_rdata_o,
   output logic                    reg_err_o,
   input  logic [NoSlvPorts-1:0]   txn_start_i,
   input  logic [NoSlvPorts-1:0]   txn_end_i,
   output logic [NoSlvPorts-1:0]   quiesce_o,
   output logic [NoSlvPorts-1:0]   port_en_o,
   output logic                    snoop_en_o,
   output logic                    amo_hotfix_o,
   output logic [CmAddrWidth-1:0]  cm_addr_base_o,
   output logic                    cfg_update_o,
   output logic                    irq_o
);

   localparam int unsigned TmoWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
   localparam logic [TmoWidth-1:0]   TmoLast = TmoWidth'(TimeoutCycles - 1);
   localparam logic [OutstWidth-1:0] CntMax  = '1;

   localparam logic [RegAddrWidth-1:0] AddrCtrl   = RegAddrWidth'('h00);
   localparam logic [RegAddrWidth-1:0] AddrPortEn = RegAddrWidth'('h04);
   localparam logic [RegAddrWidth-1:0] AddrMode   = RegAddrWidth'('h08);
   localparam logic [RegAddrWidth-1:0] AddrCmBase = RegAddrWidth'('h0C);
   localparam logic [RegAddrWidth-1:0] AddrStatus = RegAddrWidth'('h10);
   localparam logic [RegAddrWidth-1:0] AddrOutst  = RegAddrWidth'('h14);

   typedef enum logic [1:0] {IDLE, DRAIN, APPLY} state_e;

   state_e                  state_q;
   logic [TmoWidth-1:0]     tmo_q;
   logic [NoSlvPorts-1:0]   port_en_shadow_q;
   logic [1:0]              mode_shadow_q;
   logic [CmAddrWidth-1:0]  cm_shadow_q;
   // sticky[0] = timeout_err, sticky[1] = cnt_overflow, sticky[2] = cnt_underflow
   logic [2:0]              sticky_q, sticky_d;
   logic [OutstWidth-1:0]   cnt_q [NoSlvPorts];
   logic [OutstWidth-1:0]   cnt_d [NoSlvPorts];

   logic        busy, all_zero, ovf_evt, unf_evt, tmo_evt;
   logic        wr_ctrl, wr_port_en, wr_mode, wr_cm, wr_status;
   logic        commit, abort;
   logic        rsp_err;
   logic [31:0] rsp_rdata, outst_sum;
   logic [63:0] sum_wide;

   assign reg_ready_o = 1'b1;
   assign busy        = (state_q != IDLE);
   assign commit      = wr_ctrl & reg_wdata_i[0];
   assign abort       = wr_ctrl & reg_wdata_i[1];

   // Register decode: classify the request and build the read response.
   always_comb begin
      // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
      rsp_err    = 1'b0;
      rsp_rdata  = '0;
      wr_ctrl    = 1'b0;
      wr_port_en = 1'b0;
      wr_mode    = 1'b0;
      wr_cm      = 1'b0;
      wr_status  = 1'b0;
      if (reg_req_i) begin
         unique case (reg_addr_i)
            AddrCtrl: begin
               // A commit while busy is refused; an abort alone is always accepted.
               if (reg_we_i) begin
                  if (reg_wdata_i[0] && busy) rsp_err = 1'b1;
                  else                        wr_ctrl = 1'b1;
               end
            end
            AddrPortEn: begin
               if (!reg_we_i)  rsp_rdata  = 32'(port_en_shadow_q);
               else if (busy)  rsp_err    = 1'b1;
               else            wr_port_en = 1'b1;
            end
            AddrMode: begin
               if (!reg_we_i)  rsp_rdata = 32'(mode_shadow_q);
               else if (busy)  rsp_err   = 1'b1;
               else            wr_mode   = 1'b1;
            end
            AddrCmBase: begin
               if (!reg_we_i)  rsp_rdata = 32'(cm_shadow_q);
               else if (busy)  rsp_err   = 1'b1;
               else            wr_cm     = 1'b1;
            end
            AddrStatus: begin
               if (reg_we_i) wr_status = 1'b1;
               else          rsp_rdata = {28'd0, sticky_q, busy};
            end
            AddrOutst: begin
               if (!reg_we_i) rsp_rdata = outst_sum;
            end
            // Unaligned addresses never match a word address and land here too.
            default: rsp_err = 1'b1;
         endcase
      end
   end

   // Next counter values and overflow/underflow events for all ports.
   always_comb begin
      cnt_d   = cnt_q;
      ovf_evt = 1'b0;
      unf_evt = 1'b0;
      for (int p = 0; p < NoSlvPorts; p++) begin
         if (txn_start_i[p] && !txn_end_i[p]) begin
            if (cnt_q[p] == CntMax) ovf_evt  = 1'b1;
            else                    cnt_d[p] = cnt_q[p] + OutstWidth'(1);
         end else if (txn_end_i[p] && !txn_start_i[p]) begin
            if (cnt_q[p] == '0) unf_evt  = 1'b1;
            else                cnt_d[p] = cnt_q[p] - OutstWidth'(1);
         end
      end
   end

   // Drain detection and the saturated total of outstanding transactions.
   always_comb begin
      sum_wide = '0;
      all_zero = 1'b1;
      for (int p = 0; p < NoSlvPorts; p++) begin
         sum_wide = sum_wide + 64'(cnt_q[p]);
         if (cnt_q[p] != '0) all_zero = 1'b0;
      end
      outst_sum = (|sum_wide[63:32]) ? '1 : sum_wide[31:0];
   end

   // A timeout only fires when neither abort nor a completed drain takes precedence.
   assign tmo_evt  = (state_q == DRAIN) && !abort && !all_zero && (tmo_q == TmoLast);
   // Newly raised events win over a write-1-to-clear in the same cycle.
   assign sticky_d = (sticky_q & ~(wr_status ? reg_wdata_i[3:1] : 3'b000))
                   | {unf_evt, ovf_evt, tmo_evt};

   // Commit sequencer: IDLE -> DRAIN -> APPLY -> IDLE, with registered outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= IDLE;
         tmo_q          <= '0;
         quiesce_o      <= '0;
         cfg_update_o   <= 1'b0;
         port_en_o      <= PortEnRst;
         snoop_en_o     <= 1'b0;
         amo_hotfix_o   <= 1'b0;
         cm_addr_base_o <= CmAddrBaseRst;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         cfg_update_o <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (commit) begin
                  state_q   <= DRAIN;
                  tmo_q     <= '0;
                  quiesce_o <= '1;
               end
            end
            DRAIN: begin
               if (abort) begin
                  state_q   <= IDLE;
                  quiesce_o <= '0;
               end else if (all_zero) begin
                  state_q        <= APPLY;
                  cfg_update_o   <= 1'b1;
                  port_en_o      <= port_en_shadow_q;
                  snoop_en_o     <= mode_shadow_q[0];
                  amo_hotfix_o   <= mode_shadow_q[1];
                  cm_addr_base_o <= cm_shadow_q;
               end else if (tmo_q == TmoLast) begin
                  state_q   <= IDLE;
                  quiesce_o <= '0;
               end else begin
                  tmo_q <= tmo_q + TmoWidth'(1);
               end
            end
            APPLY: begin
               state_q   <= IDLE;
               quiesce_o <= '0;
            end
            default: begin
               state_q   <= IDLE;
               quiesce_o <= '0;
            end
         endcase
      end
   end

   // Shadow registers, sticky status, interrupt and register response.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         port_en_shadow_q <= PortEnRst;
         mode_shadow_q    <= 2'b00;
         cm_shadow_q      <= CmAddrBaseRst;
         sticky_q         <= 3'b000;
         irq_o            <= 1'b0;
         reg_rvalid_o     <= 1'b0;
         reg_rdata_o      <= '0;
         reg_err_o        <= 1'b0;
      end else begin
         if (wr_port_en) port_en_shadow_q <= reg_wdata_i[NoSlvPorts-1:0];
         if (wr_mode)    mode_shadow_q    <= reg_wdata_i[1:0];
         if (wr_cm)      cm_shadow_q      <= reg_wdata_i[CmAddrWidth-1:0];
         sticky_q     <= sticky_d;
         irq_o        <= |sticky_d;
         reg_rvalid_o <= reg_req_i;
         reg_rdata_o  <= rsp_rdata;
         reg_err_o    <= rsp_err;
      end
   end

   // Per-port outstanding counters; they track in every FSM state.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         // NOTE: the counter array is a handful of flops, not a RAM, so resetting every entry is intended.
         for (int p = 0; p < NoSlvPorts; p++) cnt_q[p] <= '0;
      end else begin
         for (int p = 0; p < NoSlvPorts; p++) cnt_q[p] <= cnt_d[p];
      end
   end

endmodule
